// File: rtl/risc_ctrl_pkg.sv
// Shared control definitions for the 8-bit RISC sequencer:
// state codes, opcode map, class vector layout and class helpers.
package risc_ctrl_pkg;

  localparam int MEM_TIMEOUT_DEF = 15;

  localparam logic [2:0] S_HALT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam int OP_HALT = 1;
  localparam int OP_LDR  = 9;

  localparam int C_NOP    = 0;
  localparam int C_HALT   = 1;
  localparam int C_ALU_PC = 2;
  localparam int C_ALU_RR = 3;
  localparam int C_ALU_RI = 4;
  localparam int C_STORE  = 5;
  localparam int C_LOAD   = 6;
  localparam int C_OUT    = 7;
  localparam int C_IN     = 8;
  localparam int C_POP    = 9;
  localparam int C_PUSH   = 10;
  localparam int C_JMP    = 11;
  localparam int C_JZ     = 12;
  localparam int C_JNZ    = 13;
  localparam int C_JC     = 14;
  localparam int C_JNC    = 15;
  localparam int NCLS     = 16;

  typedef logic [NCLS-1:0] cls_t;

  typedef struct packed {
    logic pc_enable;
    logic pc_update;
    logic reg_read;
    logic reg_write;
    logic alu_save;
    logic zflag_save;
    logic cflag_save;
    logic sram_read;
    logic sram_write;
    logic stack_read;
    logic stack_write;
    logic inport_read;
    logic outport_write;
    logic halted;
  } ctrl_t;

  function automatic logic is_alu(input cls_t c);
    return c[C_ALU_PC] | c[C_ALU_RR] | c[C_ALU_RI];
  endfunction

  function automatic logic is_alu_flags(input cls_t c);
    return c[C_ALU_RR] | c[C_ALU_RI];
  endfunction

  function automatic logic is_mem(input cls_t c);
    return c[C_STORE] | c[C_LOAD] | c[C_OUT]
         | c[C_IN] | c[C_POP] | c[C_PUSH];
  endfunction

  function automatic logic is_reg_wr(input cls_t c);
    return is_alu_flags(c) | c[C_LOAD]
         | c[C_IN] | c[C_POP];
  endfunction

  function automatic logic is_reg_rd(input cls_t c,
                                     input logic ldr);
    return is_alu(c) | c[C_STORE] | (c[C_LOAD] & ldr)
         | c[C_OUT] | c[C_PUSH];
  endfunction

  function automatic logic is_alu_save(input cls_t c);
    return is_alu(c) | c[C_STORE] | c[C_OUT] | c[C_PUSH];
  endfunction

  function automatic logic pc_taken(input cls_t c,
                                    input logic z,
                                    input logic cf);
    return c[C_ALU_PC] | c[C_JMP]
         | (c[C_JZ] & z)  | (c[C_JNZ] & ~z)
         | (c[C_JC] & cf) | (c[C_JNC] & ~cf);
  endfunction

endpackage

// File: rtl/op_class_decode.sv
// Opcode to one-hot instruction class; unmapped codes fall to NOP.
// Shared by the sequencer and the PC/register muxes.
module op_class_decode
  import risc_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0]  opcode,
  output logic [NCLS-1:0] cls
);

  logic [31:0] op;
  assign op = 32'(opcode);

  always_comb begin
    cls = '0;
    case (op)
      32'd1:                      cls[C_HALT]   = 1'b1;
      32'd3, 32'd4:               cls[C_ALU_PC] = 1'b1;
      32'd5, 32'd6, 32'd7,
      32'd27, 32'd28,
      32'd29, 32'd30:             cls[C_ALU_RR] = 1'b1;
      32'd21, 32'd23, 32'd24,
      32'd25, 32'd26:             cls[C_ALU_RI] = 1'b1;
      32'd8, 32'd19:              cls[C_STORE]  = 1'b1;
      32'd9, 32'd20:              cls[C_LOAD]   = 1'b1;
      32'd10:                     cls[C_OUT]    = 1'b1;
      32'd11:                     cls[C_IN]     = 1'b1;
      32'd12:                     cls[C_POP]    = 1'b1;
      32'd13:                     cls[C_PUSH]   = 1'b1;
      32'd14:                     cls[C_JMP]    = 1'b1;
      32'd15:                     cls[C_JZ]     = 1'b1;
      32'd16:                     cls[C_JNZ]    = 1'b1;
      32'd17:                     cls[C_JC]     = 1'b1;
      32'd18:                     cls[C_JNC]    = 1'b1;
      default:                    cls[C_NOP]    = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FSM, memory stall timeout and
// Moore outputs registered from the next state.
module instr_sequencer
  import risc_ctrl_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int TOW         = 4
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zflag,
  input  logic           cflag,
  input  logic           mem_ready,
  input  logic           run,
  output logic [4:0]     phase,
  output logic           pc_enable,
  output logic           pc_update,
  output logic           reg_read,
  output logic           reg_write,
  output logic           alu_save,
  output logic           zflag_save,
  output logic           cflag_save,
  output logic           sram_read,
  output logic           sram_write,
  output logic           stack_read,
  output logic           stack_write,
  output logic           inport_read,
  output logic           outport_write,
  output logic           halted,
  output logic           mem_err
);

  localparam logic [TOW-1:0] TO_LAST = TOW'(MEM_TIMEOUT - 1);

  logic [NCLS-1:0] cls;
  logic            ldr;
  logic [2:0]      state_q, state_d;
  logic [TOW-1:0]  cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [4:0]      phase_q, phase_d;
  ctrl_t           out_q, out_d;

  op_class_decode #(.OPW(OPW)) u_dec (
    .opcode (opcode),
    .cls    (cls)
  );

  assign ldr = (32'(opcode) == OP_LDR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_HALT:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = is_mem(cls) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready) begin
          state_d = S_WB;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          // abort skips WB so no register write happens
          state_d = S_FETCH;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        if (run && !cls[C_HALT]) state_d = S_FETCH;
        else                     state_d = S_HALT;
      end
      default:  state_d = S_HALT;
    endcase
  end

  always_comb begin
    out_d   = '0;
    phase_d = '0;
    case (state_d)
      S_FETCH: begin
        phase_d         = 5'b00001;
        out_d.pc_enable = 1'b1;
      end
      S_DECODE: begin
        phase_d        = 5'b00010;
        out_d.reg_read = is_reg_rd(cls, ldr);
      end
      S_EXEC: begin
        phase_d          = 5'b00100;
        out_d.alu_save   = is_alu_save(cls);
        out_d.zflag_save = is_alu_flags(cls);
        out_d.cflag_save = is_alu_flags(cls);
      end
      S_MEM: begin
        phase_d             = 5'b01000;
        out_d.sram_write    = cls[C_STORE];
        out_d.sram_read     = cls[C_LOAD];
        out_d.outport_write = cls[C_OUT];
        out_d.inport_read   = cls[C_IN];
        out_d.stack_read    = cls[C_POP];
        out_d.stack_write   = cls[C_PUSH];
      end
      S_WB: begin
        phase_d         = 5'b10000;
        out_d.reg_write = is_reg_wr(cls);
        out_d.pc_update = pc_taken(cls, zflag, cflag);
      end
      default: out_d.halted = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_HALT;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      phase_q      <= '0;
      out_q        <= '0;
      out_q.halted <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      phase_q <= phase_d;
      out_q   <= out_d;
    end
  end

  assign phase         = phase_q;
  assign pc_enable     = out_q.pc_enable;
  assign pc_update     = out_q.pc_update;
  assign reg_read      = out_q.reg_read;
  assign reg_write     = out_q.reg_write;
  assign alu_save      = out_q.alu_save;
  assign zflag_save    = out_q.zflag_save;
  assign cflag_save    = out_q.cflag_save;
  assign sram_read     = out_q.sram_read;
  assign sram_write    = out_q.sram_write;
  assign stack_read    = out_q.stack_read;
  assign stack_write   = out_q.stack_write;
  assign inport_read   = out_q.inport_read;
  assign outport_write = out_q.outport_write;
  assign halted        = out_q.halted;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle checks of the
// packed output word against hand-built expected words.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       Reset;
  logic [4:0] opcode;
  logic       zflag, cflag, mem_ready, run;
  logic [4:0] phase;
  logic       pc_enable, pc_update, reg_read, reg_write;
  logic       alu_save, zflag_save, cflag_save;
  logic       sram_read, sram_write, stack_read, stack_write;
  logic       inport_read, outport_write, halted, mem_err;

  int checks   = 0;
  int failures = 0;

  localparam logic [19:0] T0  = 20'h08000;
  localparam logic [19:0] T1  = 20'h10000;
  localparam logic [19:0] T2  = 20'h20000;
  localparam logic [19:0] T3  = 20'h40000;
  localparam logic [19:0] T4  = 20'h80000;
  localparam logic [19:0] PCE = 20'h04000;
  localparam logic [19:0] PCU = 20'h02000;
  localparam logic [19:0] RR  = 20'h01000;
  localparam logic [19:0] RW  = 20'h00800;
  localparam logic [19:0] ALU = 20'h00400;
  localparam logic [19:0] ZS  = 20'h00200;
  localparam logic [19:0] CS  = 20'h00100;
  localparam logic [19:0] SR  = 20'h00080;
  localparam logic [19:0] SW  = 20'h00040;
  localparam logic [19:0] KW  = 20'h00010;
  localparam logic [19:0] HLT = 20'h00002;
  localparam logic [19:0] ERR = 20'h00001;

  logic [19:0] obs;
  assign obs = {phase, pc_enable, pc_update, reg_read, reg_write,
                alu_save, zflag_save, cflag_save, sram_read,
                sram_write, stack_read, stack_write, inport_read,
                outport_write, halted, mem_err};

  instr_sequencer dut (
    .clk           (clk),
    .Reset         (Reset),
    .opcode        (opcode),
    .zflag         (zflag),
    .cflag         (cflag),
    .mem_ready     (mem_ready),
    .run           (run),
    .phase         (phase),
    .pc_enable     (pc_enable),
    .pc_update     (pc_update),
    .reg_read      (reg_read),
    .reg_write     (reg_write),
    .alu_save      (alu_save),
    .zflag_save    (zflag_save),
    .cflag_save    (cflag_save),
    .sram_read     (sram_read),
    .sram_write    (sram_write),
    .stack_read    (stack_read),
    .stack_write   (stack_write),
    .inport_read   (inport_read),
    .outport_write (outport_write),
    .halted        (halted),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [19:0] exp);
    @(negedge clk);
    chk(tag, exp);
  endtask

  // called in FETCH; mem_err is already sticky at this point
  task automatic branch(input string tag, input logic [4:0] op,
                        input logic z, input logic c,
                        input logic [19:0] wb);
    opcode = op;
    zflag  = z;
    cflag  = c;
    cyc({tag, "_t1"}, T1 | ERR);
    cyc({tag, "_t2"}, T2 | ERR);
    cyc({tag, "_t4"}, T4 | ERR | wb);
    cyc({tag, "_t0"}, T0 | PCE | ERR);
  endtask

  initial begin
    Reset     = 1'b0;
    run       = 1'b0;
    opcode    = 5'd0;
    zflag     = 1'b0;
    cflag     = 1'b0;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", HLT);

    Reset  = 1'b1;
    run    = 1'b1;
    opcode = 5'd5;
    cyc("rr_t0", T0 | PCE);
    cyc("rr_t1", T1 | RR);
    cyc("rr_t2", T2 | ALU | ZS | CS);
    cyc("rr_t4", T4 | RW);
    cyc("rr_next", T0 | PCE);

    opcode = 5'd20;
    cyc("ld_t1", T1);
    cyc("ld_t2", T2);
    cyc("ld_m1", T3 | SR);
    cyc("ld_m2", T3 | SR);
    cyc("ld_m3", T3 | SR);
    mem_ready = 1'b1;
    cyc("ld_t4", T4 | RW);
    mem_ready = 1'b0;
    cyc("ld_next", T0 | PCE);

    opcode = 5'd8;
    cyc("st_t1", T1 | RR);
    cyc("st_t2", T2 | ALU);
    for (int i = 0; i < 15; i++) cyc("st_mem", T3 | SW);
    cyc("st_abort", T0 | PCE | ERR);

    branch("jz_take", 5'd15, 1'b1, 1'b0, PCU);
    branch("jz_not",  5'd15, 1'b0, 1'b0, '0);
    branch("jc_take", 5'd17, 1'b0, 1'b1, PCU);
    branch("jc_not",  5'd17, 1'b0, 1'b0, '0);
    branch("jnz_take", 5'd16, 1'b0, 1'b0, PCU);

    opcode = 5'd13;
    cyc("push_t1", T1 | RR | ERR);
    cyc("push_t2", T2 | ALU | ERR);
    cyc("push_m1", T3 | KW | ERR);
    run = 1'b0;
    cyc("push_m2", T3 | KW | ERR);
    mem_ready = 1'b1;
    cyc("push_t4", T4 | ERR);
    mem_ready = 1'b0;
    cyc("push_halt", HLT | ERR);
    cyc("halt_hold", HLT | ERR);

    opcode = 5'd1;
    run    = 1'b1;
    cyc("hop_t0", T0 | PCE | ERR);
    cyc("hop_t1", T1 | ERR);
    cyc("hop_t2", T2 | ERR);
    cyc("hop_t4", T4 | ERR);
    cyc("hop_halt", HLT | ERR);

    opcode = 5'd13;
    cyc("rp_t0", T0 | PCE | ERR);
    cyc("rp_t1", T1 | RR | ERR);
    cyc("rp_t2", T2 | ALU | ERR);
    cyc("rp_m1", T3 | KW | ERR);
    #2 Reset = 1'b0;
    #1 chk("rst_mid_mem", HLT);
    @(negedge clk);
    chk("rst_hold", HLT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
